// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register index, PC and
// controller state. The PIPE_HAZARD_PERF_EN macro (used in pipe_hazard_ctrl)
// enables the optional performance counters.
package pipe_hazard_ctrl_pkg;

  localparam int NUM_GPR = 32;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] pc_t;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_FLUSH,
    HZ_DRAIN
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute handshake, retire, redirect and status signals of the hazard
// controller. The master modport is the pipeline side, the slave modport the
// controller itself.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic     id_valid_i;
  logic     id_ready_o;
  reg_idx_t id_rs1_i;
  logic     id_rs1_used_i;
  reg_idx_t id_rs2_i;
  logic     id_rs2_used_i;
  reg_idx_t id_rd_i;
  logic     id_rd_wen_i;
  logic     ex_valid_o;
  logic     ex_ready_i;
  logic     retire_valid_i;
  reg_idx_t retire_rd_i;
  logic     retire_wen_i;
  logic     redirect_i;
  pc_t      redirect_pc_i;
  logic     flush_o;
  pc_t      redirect_pc_o;
  logic     err_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs1_used_i, id_rs2_i, id_rs2_used_i,
           id_rd_i, id_rd_wen_i, ex_ready_i, retire_valid_i, retire_rd_i,
           retire_wen_i, redirect_i, redirect_pc_i,
    input  id_ready_o, ex_valid_o, flush_o, redirect_pc_o, err_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs1_used_i, id_rs2_i, id_rs2_used_i,
           id_rd_i, id_rd_wen_i, ex_ready_i, retire_valid_i, retire_rd_i,
           retire_wen_i, redirect_i, redirect_pc_i,
    output id_ready_o, ex_valid_o, flush_o, redirect_pc_o, err_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// hz_scoreboard: per-register in-flight write counters. Answers busy lookups
// for the two sources, saturation for the destination, reports when nothing
// is in flight, and flags retires that arrive for an idle register.
module hz_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  reg_idx_t rs1_i,
  input  reg_idx_t rs2_i,
  input  reg_idx_t rd_i,
  input  logic     inc_i,
  input  logic     dec_i,
  input  reg_idx_t dec_rd_i,
  output logic     rs1_busy_o,
  output logic     rs2_busy_o,
  output logic     rd_sat_o,
  output logic     all_zero_o,
  output logic     err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] cnt_q [NUM_GPR];
  logic [CNT_W-1:0] cnt_d [NUM_GPR];
  logic             err_q;
  logic             err_d;

  // Counter update: issue increments, retire decrements, both at once cancel; x0 never counts.
  always_comb begin
    for (int r = 0; r < NUM_GPR; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    err_d = err_q;
    for (int r = 1; r < NUM_GPR; r++) begin
      if (inc_i && (rd_i == reg_idx_t'(r)) && !(dec_i && (dec_rd_i == reg_idx_t'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_i && (dec_rd_i == reg_idx_t'(r)) && !(inc_i && (rd_i == reg_idx_t'(r)))
                   && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
    if (dec_i && (cnt_q[dec_rd_i] == '0)) begin
      err_d = 1'b1;
    end
  end

  // Counter array and sticky underflow error register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_GPR; r++) begin
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_GPR; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  // Empty detection used by the drain phase of a redirect.
  always_comb begin
    all_zero_o = 1'b1;
    for (int r = 0; r < NUM_GPR; r++) begin
      if (cnt_q[r] != '0) all_zero_o = 1'b0;
    end
  end

  assign rs1_busy_o = (rs1_i != '0) && (cnt_q[rs1_i] != '0);
  assign rs2_busy_o = (rs2_i != '0) && (cnt_q[rs2_i] != '0);
  assign rd_sat_o   = cnt_q[rd_i] == CNT_MAX;
  assign err_o      = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID->EX issue gate. Stalls on RAW hazards and WAW counter
// saturation, and sequences redirects as a one-cycle flush followed by a drain
// until no writes are in flight. Define PIPE_HAZARD_PERF_EN to add the
// stall_cyc_o / flush_cnt_o performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_hazard_ctrl_if.slave  bus
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]        stall_cyc_o,
  output logic [31:0]        flush_cnt_o
`endif
);

  hz_state_e state_q, state_d;
  pc_t       pc_q, pc_d;
  logic      rs1_busy, rs2_busy, rd_sat, all_zero, sb_err;
  logic      hazard, issue, inc, dec, run;

  hz_scoreboard #(.CNT_W(CNT_W)) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rs1_i      (bus.id_rs1_i),
    .rs2_i      (bus.id_rs2_i),
    .rd_i       (bus.id_rd_i),
    .inc_i      (inc),
    .dec_i      (dec),
    .dec_rd_i   (bus.retire_rd_i),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rd_sat_o   (rd_sat),
    .all_zero_o (all_zero),
    .err_o      (sb_err)
  );

  assign run    = state_q == HZ_RUN;
  assign hazard = (bus.id_rs1_used_i & rs1_busy) | (bus.id_rs2_used_i & rs2_busy)
                | (bus.id_rd_wen_i & (bus.id_rd_i != '0) & rd_sat);
  assign issue  = bus.ex_valid_o & bus.ex_ready_i;
  assign inc    = issue & bus.id_rd_wen_i & (bus.id_rd_i != '0);
  assign dec    = bus.retire_valid_i & bus.retire_wen_i & (bus.retire_rd_i != '0);

  assign bus.ex_valid_o    = bus.id_valid_i & ~hazard & run & ~bus.redirect_i;
  assign bus.id_ready_o    = issue;
  assign bus.flush_o       = state_q == HZ_FLUSH;
  assign bus.redirect_pc_o = pc_q;
  assign bus.err_o         = sb_err;

  // Redirect sequencing: any redirect (re)starts the flush, then drain until empty.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (bus.redirect_i) begin
      state_d = HZ_FLUSH;
      pc_d    = bus.redirect_pc_i;
    end else begin
      case (state_q)
        HZ_FLUSH: state_d = HZ_DRAIN;
        HZ_DRAIN: if (all_zero) state_d = HZ_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  // State and latched redirect target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HZ_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Perf counters: hazard stall cycles while running, and entries into the flush state.
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.id_valid_i && hazard && run) stall_cyc_d = stall_cyc_q + 32'd1;
    if (bus.redirect_i) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Perf counter registers, wrapping naturally at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cyc_o = stall_cyc_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: a directed vector table, hand-written
// redirect/reset sequences, and a randomized run against a queue-based model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int SAT = 3;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  pipe_hazard_ctrl_if bus();

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cyc;
  logic [31:0] flush_cnt;
`endif

  pipe_hazard_ctrl #(.CNT_W(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .stall_cyc_o (stall_cyc),
    .flush_cnt_o (flush_cnt)
`endif
  );

  // Free-running clock, rising edge active.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic     idv;
    logic     rs1u;
    reg_idx_t rs1;
    logic     rs2u;
    reg_idx_t rs2;
    logic     wen;
    reg_idx_t rd;
    logic     rdy;
    logic     rtv;
    reg_idx_t rtrd;
    logic     exp_v;
    logic     exp_err;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: in-flight writes as a plain list, redirect phase as flags.
  reg_idx_t inflight[$];
  bit       m_flush;
  bit       m_drain;
  bit       m_err;
  pc_t      m_pc;

  function automatic vec_t mk(logic idv, logic rs1u, int rs1, logic rs2u, int rs2,
                              logic wen, int rd, logic rdy, logic rtv, int rtrd,
                              logic exp_v, logic exp_err);
    vec_t v;
    v.idv = idv; v.rs1u = rs1u; v.rs1 = reg_idx_t'(rs1); v.rs2u = rs2u;
    v.rs2 = reg_idx_t'(rs2); v.wen = wen; v.rd = reg_idx_t'(rd); v.rdy = rdy;
    v.rtv = rtv; v.rtrd = reg_idx_t'(rtrd); v.exp_v = exp_v; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic int cnt_of(reg_idx_t r);
    int n = 0;
    foreach (inflight[i]) if (inflight[i] == r) n++;
    return n;
  endfunction

  task automatic applyStimulus(logic idv, logic rs1u, reg_idx_t rs1, logic rs2u, reg_idx_t rs2,
                               logic wen, reg_idx_t rd, logic rdy, logic rtv, reg_idx_t rtrd,
                               logic rtw, logic redir, pc_t pc);
    bus.id_valid_i     = idv;
    bus.id_rs1_used_i  = rs1u;
    bus.id_rs1_i       = rs1;
    bus.id_rs2_used_i  = rs2u;
    bus.id_rs2_i       = rs2;
    bus.id_rd_wen_i    = wen;
    bus.id_rd_i        = rd;
    bus.ex_ready_i     = rdy;
    bus.retire_valid_i = rtv;
    bus.retire_rd_i    = rtrd;
    bus.retire_wen_i   = rtw;
    bus.redirect_i     = redir;
    bus.redirect_pc_i  = pc;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(bit check_state);
    rst = 1'b1;
    idle();
    inflight.delete();
    m_flush = 0; m_drain = 0; m_err = 0; m_pc = '0;
    #4;
    if (check_state) begin
      checkOutput("reset flush_o", 32'(bus.flush_o), 0);
      checkOutput("reset redirect_pc_o", bus.redirect_pc_o, 0);
      checkOutput("reset err_o", 32'(bus.err_o), 0);
      checkOutput("reset ex_valid_o", 32'(bus.ex_valid_o), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Randomized cycle against the model; the model is updated on the clock edge.
  task automatic randomCycle();
    logic idv, rs1u, rs2u, wen, rdy, rtv, rtw, redir;
    reg_idx_t rs1, rs2, rd, rtrd;
    pc_t pc;
    int ridx;
    bit haz, exp_v, issue, empty_before, ret_hit;
    idv  = ($urandom_range(0, 9) < 7);
    rs1u = $urandom_range(0, 1); rs1 = reg_idx_t'($urandom_range(0, 7));
    rs2u = $urandom_range(0, 1); rs2 = reg_idx_t'($urandom_range(0, 7));
    wen  = $urandom_range(0, 1); rd  = reg_idx_t'($urandom_range(0, 7));
    rdy  = ($urandom_range(0, 9) < 8);
    rtv = 0; rtw = 0; rtrd = '0; ridx = -1;
    if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
      ridx = $urandom_range(0, inflight.size() - 1);
      rtv = 1; rtw = 1; rtrd = inflight[ridx];
    end else if ($urandom_range(0, 7) == 0) begin
      rtv = 1; rtw = 0; rtrd = reg_idx_t'($urandom_range(1, 31));
    end
    redir = ($urandom_range(0, 29) == 0);
    pc    = $urandom;
    applyStimulus(idv, rs1u, rs1, rs2u, rs2, wen, rd, rdy, rtv, rtrd, rtw, redir, pc);
    #4;
    haz = (rs1u && rs1 != 0 && cnt_of(rs1) > 0) || (rs2u && rs2 != 0 && cnt_of(rs2) > 0)
       || (wen && rd != 0 && cnt_of(rd) >= SAT);
    exp_v = idv && !haz && !m_flush && !m_drain && !redir;
    issue = exp_v && rdy;
    checkOutput("rand ex_valid_o", 32'(bus.ex_valid_o), 32'(exp_v));
    checkOutput("rand id_ready_o", 32'(bus.id_ready_o), 32'(issue));
    checkOutput("rand flush_o", 32'(bus.flush_o), 32'(m_flush));
    checkOutput("rand redirect_pc_o", bus.redirect_pc_o, m_pc);
    checkOutput("rand err_o", 32'(bus.err_o), 32'(m_err));
    @(posedge clk);
    empty_before = inflight.size() == 0;
    ret_hit = issue && wen && rd != 0 && ridx >= 0 && rtrd == rd;
    if (ridx >= 0 && !ret_hit) inflight.delete(ridx);
    if (issue && wen && rd != 0 && !ret_hit) inflight.push_back(rd);
    if (redir) begin
      m_flush = 1; m_drain = 0; m_pc = pc;
    end else if (m_flush) begin
      m_flush = 0; m_drain = 1;
    end else if (m_drain && empty_before) begin
      m_drain = 0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    doReset(1);

    // Directed table: RAW stall, x0, WAW saturation, ex_ready gating, issue+retire, underflow.
    vecs.push_back(mk(1,0,0,0,0, 1,5,1, 0,0, 1,0));
    vecs.push_back(mk(1,1,5,0,0, 0,0,1, 0,0, 0,0));
    vecs.push_back(mk(1,1,5,0,0, 0,0,1, 1,5, 0,0));
    vecs.push_back(mk(1,1,5,0,0, 0,0,1, 0,0, 1,0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,1, 0,0, 1,0));
    vecs.push_back(mk(1,1,0,1,0, 0,0,1, 0,0, 1,0));
    vecs.push_back(mk(1,0,0,0,0, 1,7,1, 0,0, 1,0));
    vecs.push_back(mk(1,0,0,0,0, 1,7,1, 0,0, 1,0));
    vecs.push_back(mk(1,0,0,0,0, 1,7,1, 0,0, 1,0));
    vecs.push_back(mk(1,0,0,0,0, 1,7,1, 0,0, 0,0));
    vecs.push_back(mk(1,1,8,0,7, 0,0,1, 0,0, 1,0));
    vecs.push_back(mk(1,0,0,0,0, 1,7,1, 1,7, 0,0));
    vecs.push_back(mk(1,0,0,0,0, 1,7,1, 0,0, 1,0));
    vecs.push_back(mk(1,0,0,0,0, 1,3,0, 0,0, 1,0));
    vecs.push_back(mk(1,1,3,0,0, 0,0,1, 0,0, 1,0));
    vecs.push_back(mk(1,0,0,0,0, 1,3,1, 0,0, 1,0));
    vecs.push_back(mk(1,0,0,0,0, 1,3,1, 1,3, 1,0));
    vecs.push_back(mk(1,1,3,0,0, 0,0,1, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,1, 1,3, 0,0));
    vecs.push_back(mk(1,1,3,0,0, 0,0,1, 0,0, 1,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,1, 1,9, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,1, 0,0, 0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,1, 1,7, 0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,1, 0,0, 0,1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].idv, vecs[i].rs1u, vecs[i].rs1, vecs[i].rs2u, vecs[i].rs2,
                    vecs[i].wen, vecs[i].rd, vecs[i].rdy, vecs[i].rtv, vecs[i].rtrd,
                    vecs[i].rtv, 0, 32'h0);
      #4;
      checkOutput($sformatf("vec%0d ex_valid_o", i), 32'(bus.ex_valid_o), 32'(vecs[i].exp_v));
      checkOutput($sformatf("vec%0d id_ready_o", i), 32'(bus.id_ready_o),
                  32'(vecs[i].exp_v & vecs[i].rdy));
      checkOutput($sformatf("vec%0d err_o", i), 32'(bus.err_o), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d flush_o", i), 32'(bus.flush_o), 0);
      cyc();
    end

    // Redirect with two writes in flight: one flush pulse, drain, RUN one cycle after empty.
    doReset(0);
    applyStimulus(1,0,10,0,0, 1,10,1, 0,0,0, 0, 32'h0); cyc();
    applyStimulus(1,0,11,0,0, 1,11,1, 0,0,0, 0, 32'h0); cyc();
    applyStimulus(1,0,0,0,0, 1,20,1, 0,0,0, 1, 32'h8000_0100); #4;
    checkOutput("redir same-cycle ex_valid_o", 32'(bus.ex_valid_o), 0);
    checkOutput("redir pre flush_o", 32'(bus.flush_o), 0);
    cyc();
    applyStimulus(1,0,0,0,0, 1,20,1, 0,0,0, 0, 32'h0); #4;
    checkOutput("redir flush_o", 32'(bus.flush_o), 1);
    checkOutput("redir redirect_pc_o", bus.redirect_pc_o, 32'h8000_0100);
    checkOutput("redir flush ex_valid_o", 32'(bus.ex_valid_o), 0);
    cyc(); #4;
    checkOutput("drain flush_o", 32'(bus.flush_o), 0);
    checkOutput("drain ex_valid_o 0", 32'(bus.ex_valid_o), 0);
    cyc(); #4;
    checkOutput("drain ex_valid_o 1", 32'(bus.ex_valid_o), 0);
    cyc();
    applyStimulus(1,0,0,0,0, 1,20,1, 1,10,1, 0, 32'h0); #4;
    checkOutput("drain ex_valid_o 2", 32'(bus.ex_valid_o), 0);
    cyc();
    applyStimulus(1,0,0,0,0, 1,20,1, 1,11,1, 0, 32'h0); #4;
    checkOutput("drain ex_valid_o 3", 32'(bus.ex_valid_o), 0);
    cyc();
    applyStimulus(1,0,0,0,0, 1,20,1, 0,0,0, 0, 32'h0); #4;
    checkOutput("drain empty ex_valid_o", 32'(bus.ex_valid_o), 0);
    cyc(); #4;
    checkOutput("run again ex_valid_o", 32'(bus.ex_valid_o), 1);
    checkOutput("run again flush_o", 32'(bus.flush_o), 0);
    cyc();

    // Asynchronous reset in DRAIN clears everything at once; late retire flags an error.
    doReset(0);
    applyStimulus(1,0,0,0,0, 1,12,1, 0,0,0, 0, 32'h0); cyc();
    applyStimulus(0,0,0,0,0, 0,0,0, 1,20,1, 0, 32'h0); cyc(); #4;
    checkOutput("underflow err_o", 32'(bus.err_o), 1);
    cyc();
    applyStimulus(0,0,0,0,0, 0,0,0, 0,0,0, 1, 32'h0000_1234); cyc();
    applyStimulus(1,0,0,0,0, 1,13,1, 0,0,0, 0, 32'h0); cyc(); #4;
    checkOutput("pre-reset drain ex_valid_o", 32'(bus.ex_valid_o), 0);
    checkOutput("pre-reset redirect_pc_o", bus.redirect_pc_o, 32'h0000_1234);
    #1 rst = 1'b1;
    #1;
    checkOutput("async reset ex_valid_o", 32'(bus.ex_valid_o), 1);
    checkOutput("async reset flush_o", 32'(bus.flush_o), 0);
    checkOutput("async reset err_o", 32'(bus.err_o), 0);
    checkOutput("async reset redirect_pc_o", bus.redirect_pc_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0,0,0,0,0, 0,0,0, 1,12,1, 0, 32'h0); cyc(); #4;
    checkOutput("late retire err_o", 32'(bus.err_o), 1);
    cyc();

`ifdef PIPE_HAZARD_PERF_EN
    // Five stalled cycles and two redirects.
    doReset(0);
    applyStimulus(1,0,0,0,0, 1,5,1, 0,0,0, 0, 32'h0); cyc();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1,1,5,0,0, 0,0,1, 0,0,0, 0, 32'h0); cyc();
    end
    applyStimulus(0,0,0,0,0, 0,0,0, 1,5,1, 0, 32'h0); cyc();
    idle(); cyc();
    applyStimulus(0,0,0,0,0, 0,0,0, 0,0,0, 1, 32'h40); cyc();
    idle(); cyc(); cyc();
    applyStimulus(0,0,0,0,0, 0,0,0, 0,0,0, 1, 32'h80); cyc();
    idle(); cyc(); cyc(); cyc(); #4;
    checkOutput("perf stall_cyc_o", stall_cyc, 5);
    checkOutput("perf flush_cnt_o", flush_cnt, 2);
    cyc();
`endif

    // Randomized traffic against the model.
    doReset(0);
    for (int i = 0; i < 2000; i++) begin
      randomCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
